// File: rtl/wb_spimemio_arb_if.sv
// Bus bundle between the two Wishbone masters, the arbiter and the SPI flash reader.
// Signal names carry the arbiter's point of view (_i into the arbiter, _o out of it).
interface wb_spimemio_arb_if;
  localparam int unsigned AW = 24;
  localparam int unsigned DW = 32;

  logic [AW-1:0] m0_adr_i;
  logic          m0_cyc_i;
  logic          m0_stb_i;
  logic [DW-1:0] m0_dat_o;
  logic          m0_ack_o;
  logic          m0_err_o;

  logic [AW-1:0] m1_adr_i;
  logic          m1_cyc_i;
  logic          m1_stb_i;
  logic [DW-1:0] m1_dat_o;
  logic          m1_ack_o;
  logic          m1_err_o;

  logic [AW-1:0] s_adr_o;
  logic          s_cyc_o;
  logic          s_stb_o;
  logic [DW-1:0] s_dat_i;
  logic          s_ack_i;

  logic          inv_i;

  // Arbiter side
  modport slave (
    input  m0_adr_i, m0_cyc_i, m0_stb_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_adr_i, m1_cyc_i, m1_stb_i,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output s_adr_o, s_cyc_o, s_stb_o,
    input  s_dat_i, s_ack_i,
    input  inv_i
  );

  // Environment side: both masters, the flash reader and the invalidate source
  modport master (
    output m0_adr_i, m0_cyc_i, m0_stb_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    output m1_adr_i, m1_cyc_i, m1_stb_i,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  s_adr_o, s_cyc_o, s_stb_o,
    output s_dat_i, s_ack_i,
    output inv_i
  );
endinterface

// File: rtl/wb_spimemio_arb.sv
// Two-master round-robin arbiter in front of a single SPI flash reader, with a
// one-entry read-hit buffer and a slave-wait timeout that terminates with err.
module wb_spimemio_arb #(
  parameter int unsigned TIMEOUT   = 255,
  parameter bit          HITBUF_EN = 1'b1
) (
  input logic             wb_clk_i,
  input logic             wb_rst_ni,
  wb_spimemio_arb_if.slave bus
);
  localparam int unsigned AW = 24;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [AW-1:0] s_adr_q, s_adr_d;
  logic          s_cyc_q, s_cyc_d;
  logic [DW-1:0] m0_dat_q, m0_dat_d;
  logic          m0_ack_q, m0_ack_d;
  logic          m0_err_q, m0_err_d;
  logic [DW-1:0] m1_dat_q, m1_dat_d;
  logic          m1_ack_q, m1_ack_d;
  logic          m1_err_q, m1_err_d;
  logic [AW-1:0] buf_adr_q, buf_adr_d;
  logic [DW-1:0] buf_dat_q, buf_dat_d;
  logic          buf_valid_q, buf_valid_d;
  logic          last_grant_q, last_grant_d;
  logic          grant_q, grant_d;
  logic          drop_q, drop_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  logic          pend0, pend1, gnt_any, gnt_sel, hit, gnt_cyc, abandon, timeout;
  logic [AW-1:0] gnt_adr;

  // Request decode: pending masters, round-robin pick, hit and timeout detection
  always_comb begin
    pend0   = bus.m0_cyc_i & bus.m0_stb_i & ~m0_ack_q & ~m0_err_q;
    pend1   = bus.m1_cyc_i & bus.m1_stb_i & ~m1_ack_q & ~m1_err_q;
    gnt_any = pend0 | pend1;
    gnt_sel = (pend0 & pend1) ? ~last_grant_q : pend1;
    gnt_adr = gnt_sel ? bus.m1_adr_i : bus.m0_adr_i;
    hit     = HITBUF_EN && buf_valid_q && (gnt_adr == buf_adr_q);
    gnt_cyc = grant_q ? bus.m1_cyc_i : bus.m0_cyc_i;
    abandon = drop_q | ~gnt_cyc;
    timeout = (wait_cnt_q == CW'(TIMEOUT - 1));
  end

  // State register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (gnt_any) state_d = hit ? ST_RESP : ST_WAIT;
      ST_WAIT: if (bus.s_ack_i || timeout) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values; ack and err default low so they pulse for RESP only
  always_comb begin
    s_adr_d      = s_adr_q;
    s_cyc_d      = s_cyc_q;
    m0_dat_d     = m0_dat_q;
    m0_ack_d     = 1'b0;
    m0_err_d     = 1'b0;
    m1_dat_d     = m1_dat_q;
    m1_ack_d     = 1'b0;
    m1_err_d     = 1'b0;
    buf_adr_d    = buf_adr_q;
    buf_dat_d    = buf_dat_q;
    buf_valid_d  = buf_valid_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    drop_d       = drop_q;
    wait_cnt_d   = wait_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          grant_d      = gnt_sel;
          last_grant_d = gnt_sel;
          drop_d       = 1'b0;
          if (hit) begin
            if (gnt_sel) begin
              m1_dat_d = buf_dat_q;
              m1_ack_d = 1'b1;
            end else begin
              m0_dat_d = buf_dat_q;
              m0_ack_d = 1'b1;
            end
          end else begin
            s_adr_d    = gnt_adr;
            s_cyc_d    = 1'b1;
            wait_cnt_d = '0;
          end
        end
      end
      ST_WAIT: begin
        // A master that lets go of cyc never gets a response, but the fill still lands
        if (!gnt_cyc) drop_d = 1'b1;
        if (bus.s_ack_i) begin
          s_cyc_d     = 1'b0;
          buf_adr_d   = s_adr_q;
          buf_dat_d   = bus.s_dat_i;
          buf_valid_d = 1'b1;
          if (!abandon) begin
            if (grant_q) begin
              m1_dat_d = bus.s_dat_i;
              m1_ack_d = 1'b1;
            end else begin
              m0_dat_d = bus.s_dat_i;
              m0_ack_d = 1'b1;
            end
          end
        end else if (timeout) begin
          s_cyc_d     = 1'b0;
          buf_valid_d = 1'b0;
          if (!abandon) begin
            if (grant_q) m1_err_d = 1'b1;
            else         m0_err_d = 1'b1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      ST_RESP: ;
      default: ;
    endcase

    if (bus.inv_i) buf_valid_d = 1'b0;
  end

  // Datapath and response registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      s_adr_q      <= '0;
      s_cyc_q      <= 1'b0;
      m0_dat_q     <= '0;
      m0_ack_q     <= 1'b0;
      m0_err_q     <= 1'b0;
      m1_dat_q     <= '0;
      m1_ack_q     <= 1'b0;
      m1_err_q     <= 1'b0;
      buf_adr_q    <= '0;
      buf_dat_q    <= '0;
      buf_valid_q  <= 1'b0;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      drop_q       <= 1'b0;
      wait_cnt_q   <= '0;
    end else begin
      s_adr_q      <= s_adr_d;
      s_cyc_q      <= s_cyc_d;
      m0_dat_q     <= m0_dat_d;
      m0_ack_q     <= m0_ack_d;
      m0_err_q     <= m0_err_d;
      m1_dat_q     <= m1_dat_d;
      m1_ack_q     <= m1_ack_d;
      m1_err_q     <= m1_err_d;
      buf_adr_q    <= buf_adr_d;
      buf_dat_q    <= buf_dat_d;
      buf_valid_q  <= buf_valid_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      drop_q       <= drop_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign bus.s_adr_o  = s_adr_q;
  assign bus.s_cyc_o  = s_cyc_q;
  assign bus.s_stb_o  = s_cyc_q;
  assign bus.m0_dat_o = m0_dat_q;
  assign bus.m0_ack_o = m0_ack_q;
  assign bus.m0_err_o = m0_err_q;
  assign bus.m1_dat_o = m1_dat_q;
  assign bus.m1_ack_o = m1_ack_q;
  assign bus.m1_err_o = m1_err_q;
endmodule

// File: tb/tb_wb_spimemio_arb.sv
// Directed bench for wb_spimemio_arb: a vector table of single reads plus hand-written
// sequences for round-robin ties, abandoned requests, stray acks and mid-WAIT reset.
module tb_wb_spimemio_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_spimemio_arb_if ifc ();
  wb_spimemio_arb_if ift ();

  // Second instance with a short timeout shares the same stimulus
  assign ift.m0_adr_i = ifc.m0_adr_i;
  assign ift.m0_cyc_i = ifc.m0_cyc_i;
  assign ift.m0_stb_i = ifc.m0_stb_i;
  assign ift.m1_adr_i = ifc.m1_adr_i;
  assign ift.m1_cyc_i = ifc.m1_cyc_i;
  assign ift.m1_stb_i = ifc.m1_stb_i;
  assign ift.s_dat_i  = ifc.s_dat_i;
  assign ift.s_ack_i  = ifc.s_ack_i;
  assign ift.inv_i    = ifc.inv_i;

  wb_spimemio_arb dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .bus      (ifc)
  );

  wb_spimemio_arb #(.TIMEOUT(8), .HITBUF_EN(1'b1)) dut_to (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .bus      (ift)
  );

  bit          use_to = 1'b0;
  logic [31:0] o_dat [2];
  logic        o_ack [2];
  logic        o_err [2];
  logic        o_cyc, o_stb;
  logic [23:0] o_adr;

  always_comb begin
    o_dat[0] = use_to ? ift.m0_dat_o : ifc.m0_dat_o;
    o_dat[1] = use_to ? ift.m1_dat_o : ifc.m1_dat_o;
    o_ack[0] = use_to ? ift.m0_ack_o : ifc.m0_ack_o;
    o_ack[1] = use_to ? ift.m1_ack_o : ifc.m1_ack_o;
    o_err[0] = use_to ? ift.m0_err_o : ifc.m0_err_o;
    o_err[1] = use_to ? ift.m1_err_o : ifc.m1_err_o;
    o_cyc    = use_to ? ift.s_cyc_o  : ifc.s_cyc_o;
    o_stb    = use_to ? ift.s_stb_o  : ifc.s_stb_o;
    o_adr    = use_to ? ift.s_adr_o  : ifc.s_adr_o;
  end

  typedef struct {
    bit          rst;
    bit          sel;
    bit          inv;
    bit          icap;
    int          m;
    logic [23:0] adr;
    int          lat;
    logic [31:0] sdat;
    int          ticks;
    bit          err;
    logic [31:0] dat;
    bit          slv;
  } vec_t;

  vec_t        vecs [16];
  int          n_run = 0;
  int          n_fail = 0;
  int          s_lat = 0;
  int          s_cnt = 0;
  logic [31:0] s_val = '0;
  bit          inv_cap = 1'b0;

  int          r_ticks;
  logic        r_ack, r_err, r_used, r_other;
  logic [31:0] r_dat;
  int          ord [4];
  int          exp_ord [4];
  int          n_ord;
  int          cnt [2];
  logic        seen;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, got, exp);
    end
  endtask

  task automatic set_req(input int m, input logic [23:0] adr, input logic on);
    if (m == 0) begin
      ifc.m0_adr_i = adr; ifc.m0_cyc_i = on; ifc.m0_stb_i = on;
    end else begin
      ifc.m1_adr_i = adr; ifc.m1_cyc_i = on; ifc.m1_stb_i = on;
    end
  endtask

  // One clock, then the flash-reader model: ack after s_lat cycles of strobe (0 = never)
  task automatic tick();
    @(posedge clk);
    #1;
    if (ifc.s_ack_i) begin
      ifc.s_ack_i = 1'b0;
      ifc.inv_i   = 1'b0;
      s_cnt       = 0;
    end else if (o_stb) begin
      s_cnt++;
      if (s_cnt == s_lat) begin
        ifc.s_ack_i = 1'b1;
        ifc.s_dat_i = s_val;
        if (inv_cap) ifc.inv_i = 1'b1;
      end
    end else begin
      s_cnt = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_req(0, 24'h0, 1'b0);
    set_req(1, 24'h0, 1'b0);
    ifc.s_ack_i = 1'b0;
    ifc.s_dat_i = '0;
    ifc.inv_i   = 1'b0;
    inv_cap     = 1'b0;
    s_cnt       = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic do_read(input int m, input logic [23:0] adr, input int budget,
                         output int ticks, output logic got_ack, output logic got_err,
                         output logic [31:0] dat, output logic used, output logic other);
    ticks = budget + 1; got_ack = 1'b0; got_err = 1'b0; dat = '0; used = 1'b0; other = 1'b0;
    set_req(m, adr, 1'b1);
    for (int t = 1; t <= budget; t++) begin
      tick();
      if (o_stb) used = 1'b1;
      if (o_ack[1-m] || o_err[1-m]) other = 1'b1;
      if (o_ack[m] || o_err[m]) begin
        ticks = t; got_ack = o_ack[m]; got_err = o_err[m]; dat = o_dat[m];
        break;
      end
    end
    set_req(m, adr, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //            rst sel inv icap m  adr          lat sdat          ticks err dat           slv
    vecs[0]  = '{1, 0, 0, 0, 0, 24'h000100, 66, 32'hDEADBEEF, 67, 0, 32'hDEADBEEF, 1};
    vecs[1]  = '{0, 0, 0, 0, 0, 24'h000100, 0,  32'h00000000, 1,  0, 32'hDEADBEEF, 0};
    vecs[2]  = '{0, 0, 0, 0, 1, 24'h000100, 0,  32'h00000000, 1,  0, 32'hDEADBEEF, 0};
    vecs[3]  = '{0, 0, 0, 0, 1, 24'h000101, 3,  32'h11111111, 4,  0, 32'h11111111, 1};
    vecs[4]  = '{0, 0, 0, 0, 0, 24'h000100, 2,  32'h22222222, 3,  0, 32'h22222222, 1};
    vecs[5]  = '{0, 0, 0, 0, 0, 24'h800100, 1,  32'h33333333, 2,  0, 32'h33333333, 1};
    vecs[6]  = '{0, 0, 0, 0, 0, 24'h800100, 0,  32'h00000000, 1,  0, 32'h33333333, 0};
    vecs[7]  = '{0, 0, 1, 0, 0, 24'h800100, 2,  32'h44444444, 3,  0, 32'h44444444, 1};
    vecs[8]  = '{0, 0, 0, 0, 1, 24'h800100, 0,  32'h00000000, 1,  0, 32'h44444444, 0};
    vecs[9]  = '{0, 0, 0, 1, 0, 24'h000600, 2,  32'h55555555, 3,  0, 32'h55555555, 1};
    vecs[10] = '{0, 0, 0, 0, 0, 24'h000600, 1,  32'h66666666, 2,  0, 32'h66666666, 1};
    vecs[11] = '{1, 1, 0, 0, 1, 24'h000400, 2,  32'h77777777, 3,  0, 32'h77777777, 1};
    vecs[12] = '{0, 1, 0, 0, 1, 24'h000200, 0,  32'h00000000, 9,  1, 32'h00000000, 1};
    vecs[13] = '{0, 1, 0, 0, 0, 24'h000400, 2,  32'h88888888, 3,  0, 32'h88888888, 1};
    vecs[14] = '{0, 1, 0, 0, 1, 24'h000500, 8,  32'h99999999, 9,  0, 32'h99999999, 1};
    vecs[15] = '{0, 1, 0, 0, 1, 24'h000500, 0,  32'h00000000, 1,  0, 32'h99999999, 0};
    exp_ord  = '{0, 1, 0, 1};

    // Reset values while reset is held
    set_req(0, 24'h0, 1'b0);
    set_req(1, 24'h0, 1'b0);
    ifc.s_ack_i = 1'b0;
    ifc.s_dat_i = '0;
    ifc.inv_i   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst s_cyc", 32'(o_cyc), 32'd0);
    check("rst s_stb", 32'(o_stb), 32'd0);
    check("rst s_adr", 32'(o_adr), 32'd0);
    check("rst m0_ack", 32'(o_ack[0]), 32'd0);
    check("rst m1_ack", 32'(o_ack[1]), 32'd0);
    check("rst m0_err", 32'(o_err[0]), 32'd0);
    check("rst m1_err", 32'(o_err[1]), 32'd0);
    check("rst m0_dat", o_dat[0], 32'd0);
    check("rst m1_dat", o_dat[1], 32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      use_to  = vecs[i].sel;
      s_lat   = vecs[i].lat;
      s_val   = vecs[i].sdat;
      inv_cap = vecs[i].icap;
      if (vecs[i].inv) begin
        ifc.inv_i = 1'b1;
        tick();
        ifc.inv_i = 1'b0;
      end
      do_read(vecs[i].m, vecs[i].adr, 200, r_ticks, r_ack, r_err, r_dat, r_used, r_other);
      check($sformatf("v%0d latency", i), 32'(r_ticks), 32'(vecs[i].ticks));
      check($sformatf("v%0d ack", i), 32'(r_ack), 32'(!vecs[i].err));
      check($sformatf("v%0d err", i), 32'(r_err), 32'(vecs[i].err));
      if (!vecs[i].err) check($sformatf("v%0d dat", i), r_dat, vecs[i].dat);
      check($sformatf("v%0d slave_used", i), 32'(r_used), 32'(vecs[i].slv));
      check($sformatf("v%0d other_quiet", i), 32'(r_other), 32'd0);
      tick();
      check($sformatf("v%0d pulse", i), 32'(o_ack[vecs[i].m] | o_err[vecs[i].m]), 32'd0);
      check($sformatf("v%0d s_cyc_idle", i), 32'(o_cyc), 32'd0);
      inv_cap = 1'b0;
    end

    // Simultaneous requests from both masters, each re-requesting after its ack
    do_reset();
    use_to = 1'b0;
    s_lat  = 1;
    s_val  = 32'h0BADF00D;
    n_ord  = 0;
    cnt    = '{0, 0};
    set_req(0, 24'h010000, 1'b1);
    set_req(1, 24'h020000, 1'b1);
    for (int t = 0; t < 60 && n_ord < 4; t++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        if (o_ack[k]) begin
          if (n_ord < 4) ord[n_ord] = k;
          n_ord++;
          cnt[k]++;
          if (cnt[k] < 2) set_req(k, (k == 0) ? 24'h010004 : 24'h020004, 1'b1);
          else            set_req(k, 24'h0, 1'b0);
        end
      end
    end
    set_req(0, 24'h0, 1'b0);
    set_req(1, 24'h0, 1'b0);
    check("tie ack count", 32'(n_ord), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("tie order %0d", i), 32'(ord[i]), 32'(exp_ord[i]));
    repeat (3) tick();

    // m1 abandons its read mid-WAIT; the fill must still reach the buffer
    s_lat = 5;
    s_val = 32'hCAFEF00D;
    seen  = 1'b0;
    set_req(1, 24'h000300, 1'b1);
    repeat (2) tick();
    set_req(1, 24'h000300, 1'b0);
    for (int t = 0; t < 8; t++) begin
      tick();
      if (o_ack[1] || o_err[1]) seen = 1'b1;
    end
    check("drop no m1 resp", 32'(seen), 32'd0);
    check("drop s_cyc low", 32'(o_cyc), 32'd0);
    do_read(0, 24'h000300, 20, r_ticks, r_ack, r_err, r_dat, r_used, r_other);
    check("drop hit latency", 32'(r_ticks), 32'd1);
    check("drop hit dat", r_dat, 32'hCAFEF00D);
    check("drop hit no slave", 32'(r_used), 32'd0);
    tick();

    // A stray slave ack outside WAIT must not disturb anything
    ifc.s_ack_i = 1'b1;
    ifc.s_dat_i = 32'h0BAD0BAD;
    tick();
    tick();
    check("stray ack m0", 32'(o_ack[0]), 32'd0);
    check("stray ack m1", 32'(o_ack[1]), 32'd0);
    do_read(1, 24'h000300, 20, r_ticks, r_ack, r_err, r_dat, r_used, r_other);
    check("stray hit latency", 32'(r_ticks), 32'd1);
    check("stray hit dat", r_dat, 32'hCAFEF00D);
    tick();

    // Reset asserted while waiting on the slave clears outputs without a clock edge
    s_lat = 0;
    set_req(0, 24'h000700, 1'b1);
    tick();
    tick();
    check("wait s_cyc", 32'(o_cyc), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst s_cyc", 32'(o_cyc), 32'd0);
    check("async rst s_stb", 32'(o_stb), 32'd0);
    check("async rst acks", 32'({o_ack[0], o_ack[1], o_err[0], o_err[1]}), 32'd0);
    check("async rst s_adr", 32'(o_adr), 32'd0);
    set_req(0, 24'h0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
